// File: rtl/uart_word_tx_pkg.sv
// Shared frame-format definitions for the word UART transmitter and its receiver.
// Pure definitions: no logic, no latency, no flow control.
// Both ends import this so start/data/stop framing and byte order stay in step.
package uart_word_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_BYTES_PER_WORD = 4;

endpackage

// File: rtl/sync_word_fifo.sv
// Generic synchronous FIFO with registered pointers and combinational head read.
// Latency: a pushed entry is visible on pop_data one cycle after the push edge.
// Backpressure: push is ignored while full, pop is ignored while empty.
module sync_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // The extra pointer MSB separates the wrapped-full case from empty.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// 32-bit word to 8N1 serial transmitter, LSB byte first, fed from a small word FIFO.
// Latency: push edge E -> head popped at E+1 -> start bit on tx from E+2; 40*CLKS_PER_BIT+2 cycles per word.
// Backpressure: word_ready is simply !full; a same-cycle pop never opens a full FIFO.
module uart_word_tx
  import uart_word_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic [1:0]        BYTE_LAST = 2'(UART_BYTES_PER_WORD - 1);

  tx_state_t         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [1:0]        byte_cnt;
  logic [31:0]       shreg;
  logic              word_loaded;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [31:0]       fifo_head;

  logic              baud_done;
  logic [2:0]        next_bit;
  logic [7:0]        cur_byte;

  assign word_ready = !fifo_full;
  assign fifo_pop   = (state == IDLE) && !word_loaded && !fifo_empty;
  assign busy       = !fifo_empty || word_loaded || (state != IDLE);
  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign next_bit   = bit_cnt + 3'd1;
  assign cur_byte   = shreg[7:0];

  sync_word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (word_valid),
    .push_data (word_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx          <= 1'b1;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      shreg       <= '0;
      word_loaded <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          // The head is popped one edge before the start bit so tx stays a plain register.
          if (word_loaded) begin
            word_loaded <= 1'b0;
            state       <= START;
            tx          <= 1'b0;
          end else if (!fifo_empty) begin
            shreg       <= fifo_head;
            byte_cnt    <= '0;
            word_loaded <= 1'b1;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            tx       <= cur_byte[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= next_bit;
              tx      <= cur_byte[next_bit];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (byte_cnt == BYTE_LAST) begin
              state <= IDLE;
            end else begin
              // Next byte's start bit follows the stop bit with no gap.
              byte_cnt <= byte_cnt + 2'd1;
              shreg    <= shreg >> UART_DATA_BITS;
              state    <= START;
              tx       <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
